// File: rtl/tcam_ctrl.sv
// Command front-end for an external 16-entry, 16-bit TCAM: it sequences entry writes and
// searches, holds each search result for a ready/valid consumer, and counts hits and misses.
module tcam_ctrl #(
  parameter int unsigned SEARCH_LAT = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_dontcare,
  input  logic [3:0]  cmd_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [3:0]  rsp_addr,
  output logic [15:0] tcam_data,
  output logic [15:0] tcam_dontcare,
  output logic [3:0]  tcam_write_address,
  output logic        tcam_write_readN,
  input  logic [3:0]  tcam_found_address,
  input  logic        tcam_found_any,
  input  logic        clear_counts,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {IDLE, WRITE, SEARCH, RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(SEARCH_LAT);

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [15:0] dc_q, dc_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rsp_hit_q, rsp_hit_d;
  logic [3:0]  rsp_addr_q, rsp_addr_d;
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;
  logic        capture;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    dc_d       = dc_q;
    waddr_d    = waddr_q;
    cnt_d      = cnt_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_addr_d = rsp_addr_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_data;
          if (cmd_op) begin
            dc_d    = cmd_dontcare;
            waddr_d = cmd_addr;
            state_d = WRITE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = SEARCH;
          end
        end
      end
      WRITE: state_d = IDLE;
      SEARCH: begin
        cnt_d = cnt_q - 2'd1;
        // The counter reaches zero on this edge: sample the TCAM now.
        if (cnt_q == 2'd1) begin
          capture    = 1'b1;
          rsp_hit_d  = tcam_found_any;
          rsp_addr_d = tcam_found_any ? tcam_found_address : '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a same-cycle capture; both counters stick at all-ones.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (clear_counts) begin
      hit_d  = '0;
      miss_d = '0;
    end else if (capture) begin
      if (tcam_found_any && (hit_q != '1))   hit_d  = hit_q + 16'd1;
      if (!tcam_found_any && (miss_q != '1)) miss_d = miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      data_q     <= '0;
      dc_q       <= '0;
      waddr_q    <= '0;
      cnt_q      <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_addr_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      dc_q       <= dc_d;
      waddr_q    <= waddr_d;
      cnt_q      <= cnt_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_addr_q <= rsp_addr_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign cmd_ready          = (state_q == IDLE);
  assign rsp_valid          = (state_q == RESP);
  assign tcam_write_readN   = (state_q == WRITE);
  assign tcam_data          = data_q;
  assign tcam_dontcare      = dc_q;
  assign tcam_write_address = waddr_q;
  assign rsp_hit            = rsp_hit_q;
  assign rsp_addr           = rsp_addr_q;
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Bench for tcam_ctrl: a default-latency instance behind a small behavioural TCAM, plus a
// SEARCH_LAT=3 instance with directly driven match inputs for capture-timing checks.
module tb_tcam_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        cmd_valid, cmd_op, rsp_ready, clear_counts;
  logic [15:0] cmd_data, cmd_dontcare;
  logic [3:0]  cmd_addr;
  logic        cmd_ready, rsp_valid, rsp_hit, tcam_write_readN;
  logic [3:0]  rsp_addr, tcam_write_address;
  logic [15:0] tcam_data, tcam_dontcare, hit_count, miss_count;
  logic [3:0]  tcam_found_address;
  logic        tcam_found_any;

  logic        c3_valid, c3_op, r3_ready, clr3;
  logic [15:0] c3_data, c3_dc;
  logic [3:0]  c3_addr;
  logic        c3_ready, r3_valid, r3_hit, t3_wr;
  logic [3:0]  r3_addr, t3_waddr;
  logic [15:0] t3_data, t3_dc, hit3, miss3;
  logic [3:0]  f3_addr;
  logic        f3_any;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp3_q[$];

  logic [15:0] m_data [16];
  logic [15:0] m_dc   [16];
  bit          m_valid[16];

  always #5 clk = ~clk;

  tcam_ctrl dut (
    .clk(clk), .resetN(resetN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_dontcare(cmd_dontcare), .cmd_addr(cmd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .tcam_data(tcam_data), .tcam_dontcare(tcam_dontcare),
    .tcam_write_address(tcam_write_address), .tcam_write_readN(tcam_write_readN),
    .tcam_found_address(tcam_found_address), .tcam_found_any(tcam_found_any),
    .clear_counts(clear_counts), .hit_count(hit_count), .miss_count(miss_count)
  );

  tcam_ctrl #(.SEARCH_LAT(3)) u3 (
    .clk(clk), .resetN(resetN), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_data(c3_data), .cmd_dontcare(c3_dc), .cmd_addr(c3_addr),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_hit(r3_hit), .rsp_addr(r3_addr),
    .tcam_data(t3_data), .tcam_dontcare(t3_dc),
    .tcam_write_address(t3_waddr), .tcam_write_readN(t3_wr),
    .tcam_found_address(f3_addr), .tcam_found_any(f3_any),
    .clear_counts(clr3), .hit_count(hit3), .miss_count(miss3)
  );

  // Behavioural TCAM: dontcare bit set means "ignore"; lowest matching index wins.
  always @(posedge clk) begin
    if (tcam_write_readN) begin
      m_data[tcam_write_address]  <= tcam_data;
      m_dc[tcam_write_address]    <= tcam_dontcare;
      m_valid[tcam_write_address] <= 1'b1;
    end
  end

  always_comb begin
    tcam_found_any     = 1'b0;
    tcam_found_address = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!tcam_found_any && m_valid[i] && (((tcam_data ^ m_data[i]) & ~m_dc[i]) == 16'h0)) begin
        tcam_found_any     = 1'b1;
        tcam_found_address = 4'(i);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response monitors: sample 1 time unit after the falling edge, pop and compare on handshake.
  always begin
    logic [4:0] e;
    @(negedge clk);
    #1;
    if (resetN && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual hit=%0d addr=%0d expected none", rsp_hit, rsp_addr);
      end else begin
        e = exp_q.pop_front();
        check("rsp_hit_addr", {27'd0, rsp_hit, rsp_addr}, {27'd0, e});
      end
    end
  end

  always begin
    logic [4:0] e;
    @(negedge clk);
    #1;
    if (resetN && r3_valid && r3_ready) begin
      if (exp3_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp3_unexpected actual hit=%0d addr=%0d expected none", r3_hit, r3_addr);
      end else begin
        e = exp3_q.pop_front();
        check("rsp3_hit_addr", {27'd0, r3_hit, r3_addr}, {27'd0, e});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [15:0] dc);
    wait_idle();
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = a; cmd_data = d; cmd_dontcare = dc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr_strobe_on", {31'd0, tcam_write_readN}, 32'd1);
    check("wr_addr", {28'd0, tcam_write_address}, {28'd0, a});
    check("wr_data", {16'd0, tcam_data}, {16'd0, d});
    check("wr_dc", {16'd0, tcam_dontcare}, {16'd0, dc});
    check("wr_busy", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("wr_strobe_off", {31'd0, tcam_write_readN}, 32'd0);
    check("wr_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_search(input logic [15:0] key, input logic h, input logic [3:0] a);
    wait_idle();
    exp_q.push_back({h, a});
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = key;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("srch_strobe", {31'd0, tcam_write_readN}, 32'd0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0; cmd_dontcare = '0;
    cmd_addr = '0; rsp_ready = 1'b1; clear_counts = 1'b0;
    c3_valid = 1'b0; c3_op = 1'b0; c3_data = '0; c3_dc = '0; c3_addr = '0;
    r3_ready = 1'b1; clr3 = 1'b0; f3_any = 1'b0; f3_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_tcam_data", {16'd0, tcam_data}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wr", {31'd0, tcam_write_readN}, 32'd0);
    check("rst_counts", {hit_count, miss_count}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    resetN = 1'b1;
    @(negedge clk);

    do_write(4'd12, 16'h6EEA, 16'h8787);
    do_write(4'd8, 16'h8000, 16'h3FFF);
    do_search(16'h6E6E, 1'b1, 4'd12);
    do_search(16'h9235, 1'b1, 4'd8);
    do_search(16'h0001, 1'b0, 4'd0);
    check("cnt_hit", {16'd0, hit_count}, 32'd2);
    check("cnt_miss", {16'd0, miss_count}, 32'd1);

    // Backpressure: result held while rsp_ready is low; a new command is not taken.
    rsp_ready = 1'b0;
    wait_idle();
    exp_q.push_back({1'b1, 4'd12});
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 16'h6E6E;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 4'd3; cmd_data = 16'hFFFF; cmd_dontcare = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hit_addr", {27'd0, rsp_hit, rsp_addr}, {27'd0, 1'b1, 4'd12});
      check("bp_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_no_write", {31'd0, tcam_write_readN}, 32'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("bp_waddr_kept", {28'd0, tcam_write_address}, 32'd8);
    check("bp_data_kept", {16'd0, tcam_data}, 32'h6E6E);
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("bp_counts", {hit_count, miss_count}, {16'd3, 16'd1});

    // Reset in the middle of a search discards it.
    wait_idle();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 16'h6E6E;
    @(negedge clk);
    cmd_valid = 1'b0;
    resetN = 1'b0;
    #1;
    check("mid_rst_data", {16'd0, tcam_data}, 32'd0);
    check("mid_rst_dc", {16'd0, tcam_dontcare}, 32'd0);
    check("mid_rst_waddr", {28'd0, tcam_write_address}, 32'd0);
    check("mid_rst_rsp", {26'd0, rsp_valid, rsp_hit, rsp_addr}, 32'd0);
    check("mid_rst_counts", {hit_count, miss_count}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("post_rst_counts", {hit_count, miss_count}, 32'd0);

    // Saturation: preload the hit counter just below the ceiling.
    force dut.hit_q = 16'hFFFD;
    #1;
    release dut.hit_q;
    check("sat_preload", {16'd0, hit_count}, 32'hFFFD);
    do_search(16'h6E6E, 1'b1, 4'd12);
    check("sat_fffe", {16'd0, hit_count}, 32'hFFFE);
    do_search(16'h6E6E, 1'b1, 4'd12);
    check("sat_ffff", {16'd0, hit_count}, 32'hFFFF);
    do_search(16'h6E6E, 1'b1, 4'd12);
    check("sat_hold", {16'd0, hit_count}, 32'hFFFF);
    check("sat_miss", {16'd0, miss_count}, 32'd0);

    // clear_counts on the capture cycle beats the miss increment.
    wait_idle();
    exp_q.push_back({1'b0, 4'd0});
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 16'h0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    check("clr_counts", {hit_count, miss_count}, 32'd0);
    wait_idle();

    // SEARCH_LAT=3: only the match inputs of the third cycle after accept are captured.
    check("l3_ready", {31'd0, c3_ready}, 32'd1);
    exp3_q.push_back({1'b0, 4'd0});
    f3_any = 1'b1; f3_addr = 4'd5;
    c3_valid = 1'b1; c3_op = 1'b0; c3_data = 16'h1234;
    @(negedge clk);
    c3_valid = 1'b0;
    @(negedge clk);
    f3_any = 1'b1; f3_addr = 4'd9;
    @(negedge clk);
    check("l3_not_yet", {31'd0, r3_valid}, 32'd0);
    f3_any = 1'b0; f3_addr = 4'd7;
    @(negedge clk);
    check("l3_valid", {31'd0, r3_valid}, 32'd1);
    @(negedge clk);
    check("l3_ready_back", {31'd0, c3_ready}, 32'd1);
    exp3_q.push_back({1'b1, 4'd10});
    c3_valid = 1'b1;
    @(negedge clk);
    c3_valid = 1'b0; f3_any = 1'b0; f3_addr = 4'd3;
    @(negedge clk);
    @(negedge clk);
    f3_any = 1'b1; f3_addr = 4'd10;
    @(negedge clk);
    check("l3_valid2", {31'd0, r3_valid}, 32'd1);
    @(negedge clk);
    check("l3_counts", {hit3, miss3}, {16'd1, 16'd1});

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    check("sb3_drained", exp3_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcam_ctrl.md
TCAM_CTRL -- requirements
Module: tcam_ctrl

Interface
- REQ-001 SHALL have parameter SEARCH_LAT, default 1, giving the cycles from driving a search key to sampling TCAM results; legal range 1..3.
- REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
- REQ-004 SHALL have port cmd_valid, input, 1 bit: command offered.
- REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
- REQ-006 SHALL have port cmd_op, input, 1 bit: 1 = write entry, 0 = search.
- REQ-007 SHALL have port cmd_data, input, 16 bits: entry data for a write, or key for a search.
- REQ-008 SHALL have port cmd_dontcare, input, 16 bits: don't-care mask for a write; ignored for a search.
- REQ-009 SHALL have port cmd_addr, input, 4 bits: entry index for a write.
- REQ-010 SHALL have port rsp_valid, output, 1 bit: search result available.
- REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer takes the result.
- REQ-012 SHALL have port rsp_hit, output, 1 bit: the search matched an entry.
- REQ-013 SHALL have port rsp_addr, output, 4 bits: matching entry index; 0 on a miss.
- REQ-014 SHALL have port tcam_data, output, 16 bits: drives the TCAM data input.
- REQ-015 SHALL have port tcam_dontcare, output, 16 bits: drives the TCAM dontcare input.
- REQ-016 SHALL have port tcam_write_address, output, 4 bits: drives the TCAM write address.
- REQ-017 SHALL have port tcam_write_readN, output, 1 bit: 1 = TCAM write, 0 = TCAM search.
- REQ-018 SHALL have port tcam_found_address, input, 4 bits: TCAM match index.
- REQ-019 SHALL have port tcam_found_any, input, 1 bit: TCAM match flag.
- REQ-020 SHALL have port clear_counts, input, 1 bit: synchronous clear of both counters.
- REQ-021 SHALL have port hit_count, output, 16 bits: number of searches that hit.
- REQ-022 SHALL have port miss_count, output, 16 bits: number of searches that missed.

Function
- REQ-023 SHALL implement FSM states IDLE, WRITE, SEARCH, RESP; cmd_ready SHALL be 1 only in IDLE.
- REQ-024 IDLE, on cmd_valid & cmd_op=1: SHALL register cmd_data, cmd_dontcare, cmd_addr onto the tcam_* outputs and go to WRITE.
- REQ-025 WRITE: tcam_write_readN SHALL be 1 for exactly this one cycle, then the FSM returns to IDLE; a write produces no response.
- REQ-026 IDLE, on cmd_valid & cmd_op=0: SHALL register cmd_data onto tcam_data, leave tcam_dontcare and tcam_write_address unchanged, load the wait counter with SEARCH_LAT, and go to SEARCH.
- REQ-027 SEARCH: tcam_write_readN SHALL be 0; the counter decrements each cycle; in the cycle it reaches 0, SHALL capture rsp_hit=tcam_found_any and rsp_addr=(found_any ? found_address : 0), then go to RESP.
- REQ-028 RESP: rsp_valid SHALL be 1 with rsp_hit and rsp_addr held stable until rsp_ready=1; on that cycle the FSM goes to IDLE and rsp_valid falls on the next edge.
- REQ-029 tcam_write_readN SHALL be 0 in every state except WRITE; the tcam_* outputs SHALL hold their last values outside accept cycles.
- REQ-030 Per-command latency: write = 2 cycles (accept + WRITE); search = accept + SEARCH_LAT + RESP (at least 1 cycle).
- REQ-031 hit_count or miss_count SHALL increment by 1 on the capture cycle; both counters SHALL saturate at 0xFFFF.
- REQ-032 clear_counts SHALL zero both counters on the next edge; it takes priority over a same-cycle increment.
- REQ-033 cmd_valid while not IDLE SHALL be ignored; the command stays pending at the source.

Reset
- REQ-034 resetN=0 SHALL asynchronously force state IDLE and zero all registered outputs: tcam_*, rsp_*, both counters.
- REQ-035 Reset during SEARCH or RESP SHALL discard the pending result; no rsp_valid is produced and no counter changes.

Verification
- REQ-036 Write addr 12, data 0x6EEA, dontcare 0x8787 -> tcam_write_readN=1 for exactly 1 cycle with tcam_write_address=12; cmd_ready=1 again 2 cycles after accept.
- REQ-037 After REQ-036 plus write addr 8, data 0x8000, dontcare 0x3FFF: search 0x6E6E -> rsp_hit=1, rsp_addr=12; search 0x9235 -> rsp_hit=1, rsp_addr=8; search 0x0001 -> rsp_hit=0, rsp_addr=0; then hit_count=2, miss_count=1.
- REQ-038 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_hit, rsp_addr stable and cmd_ready=0 throughout; a cmd_valid presented meanwhile is not accepted.
- REQ-039 resetN pulsed low during SEARCH -> all outputs 0 immediately; no response follows; counters read 0.
- REQ-040 hit_count preloaded to 0xFFFF via 65535 hits, then one more hit -> count stays 0xFFFF; clear_counts asserted on a capture cycle -> both counters 0.
- REQ-041 With SEARCH_LAT=3 -> results are captured exactly 3 cycles after accept; a found_any change injected in an earlier cycle is not captured.
